avst_interpolator: RTL and testbench
====================================

# avst_interpolator

Avalon-ST beat interpolator: every accepted sink beat is emitted on the source (F+1) times, where F is a software-programmed interpolation factor. It is the counterpart to the stream decimator and sits in the same AFU streaming datapath. Software can expand a stream before a consumer, or restore beat count after decimation. Packet framing is preserved: SOP is marked only on the first copy of a beat, EOP and empty only on the last copy. Control is a single 64-bit CSR.

## Interface
- DATA_WIDTH, 512, streaming data width in bits
- EMPTY_WIDTH, 6, log2(DATA_WIDTH/8)
- clk  in  1  clock; all logic single-domain
- reset  in  1  asynchronous, active-high reset
- csr_write  in  1  CSR write strobe
- csr_writedata  in  64  CSR write data
- csr_byteenable  in  8  CSR byte enables
- csr_read  in  1  CSR read strobe (readdata combinational, zero wait)
- csr_readdata  out  64  CSR read data
- snk_data / snk_valid / snk_sop / snk_eop / snk_empty  in  DATA_WIDTH/1/1/1/EMPTY_WIDTH  sink beat
- snk_ready  out  1  sink backpressure (ready latency 0)
- src_data / src_valid / src_sop / src_eop / src_empty  out  DATA_WIDTH/1/1/1/EMPTY_WIDTH  source beat
- src_ready  in  1  source backpressure (ready latency 0)

## Operation
- CSR fields:
  - bit0 enable (R/W, BE0).
  - bit1 busy (RO) = holding a beat.
  - 15:2 reserved, read 0.
  - 31:16 factor F (R/W, BE2/BE3 per byte).
  - 47:32 copy_count (RO).
  - 63:48 reserved, read 0.
- Datapath: one holding register with fields held, data, sop, eop, empty, held_F, plus a 16-bit copy_count.
- held_F is latched from F on capture. A CSR write to F affects only later beats.
- last_copy = held & (copy_count == held_F).
- src_valid = held & enable. src_data = held data.
- src_sop = held sop & (copy_count == 0).
- src_eop = held eop & last_copy.
- src_empty = held empty when src_eop, else 0.
- snk_ready = enable & (!held | (src_ready & last_copy)).
- Capture occurs on snk_valid & snk_ready: held←1, copy_count←0, fields loaded, held_F←F.
- Source transfer (src_valid & src_ready), not last_copy: copy_count+1.
- Source transfer on last_copy with a simultaneous capture: load the new beat, with no bubble.
- Source transfer on last_copy without a capture: held←0, copy_count←0.
- enable=0: no acceptance and no emission. The held beat and copy_count are frozen, and the sequence resumes exactly on re-enable.
- F=0 gives a transparent pass-through with one register stage.
- F=0xFFFF gives 65536 copies. copy_count never exceeds held_F, so there is no wrap.
- SOP and EOP on the same beat: first copy carries sop, last copy carries eop. With F=0, one copy carries both.

## Timing
- Async reset values:
  - enable=0, F=0, held=0, copy_count=0, held_F=0.
  - src_valid=0, src_sop=0, src_eop=0, src_empty=0.
  - snk_ready=0.
  - csr_readdata=0.
- Reset mid-packet discards the held beat.
- Latency: a beat captured on edge N appears on the source in cycle N+1.
- Throughput: 1 sink beat per (F+1) cycles at full src_ready.
- src_valid is asserted independently of src_ready and stays stable with unchanged data/sop/eop/empty until accepted or enable drops.
- snk_ready depends combinationally on src_ready (no skid); this is intentional.
- CSR writes take effect on the next clock edge. An enable write and a stream handshake in the same cycle use the pre-write enable.

## Structure
- Package avst_interpolator_pkg holds:
  - CSR bit offsets: ENABLE_BIT=0, BUSY_BIT=1, FACTOR_LSB=16, COUNT_LSB=32.
  - CNT_W=16.
  - A typedef for held beat metadata (sop, eop, empty).
- Sub-module avst_beat_repeater contains the holding register, copy counter and framing logic, parameterised by DATA_WIDTH/EMPTY_WIDTH.
- Top level holds the CSR decode, readback, and the enable gating.

## Test plan
- Reset release, then F=2, enable=1, a 3-beat packet D0(sop),D1,D2(eop,empty=5), src_ready=1 → 9 source beats D0×3,D1×3,D2×3; sop only on beat 1; eop and empty=5 only on beat 9; snk_ready high on cycles 0,3,6.
- F=0, enable=1, 16 back-to-back beats, src_ready=1 → 16 source beats with no bubble, data delayed by 1 cycle, framing identical.
- F=3 with src_ready toggling 1,0 each cycle on a single-beat packet (sop+eop) → 4 copies total, stable while stalled, sop on copy 0, eop on copy 3.
- F=4, capture one beat, clear enable after 2 copies for 5 cycles → src_valid=0, copy_count reads 2, busy=1; on re-enable exactly 3 more copies.
- Capture a beat at F=1, write F=5 before the last copy → the held beat emits 2 copies; the next beat emits 6.
- Assert reset asynchronously while holding a beat with copy_count=2 → all outputs 0 immediately; after release, readback=0 and no stale beat is emitted.

Source files
------------

// File: rtl/avst_interpolator_pkg.sv
// Shared constants and types for the Avalon-ST beat interpolator.
package avst_interpolator_pkg;

  localparam int ENABLE_BIT = 0;
  localparam int BUSY_BIT   = 1;
  localparam int FACTOR_LSB = 16;
  localparam int COUNT_LSB  = 32;
  localparam int CNT_W      = 16;
  localparam int EMPTY_W    = 6;

  // Framing side-band captured alongside the held data word.
  typedef struct packed {
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } beat_meta_t;

endpackage

// File: rtl/avst_beat_repeater.sv
// Holds one sink beat and replays it (held_F+1) times on the source,
// keeping SOP on the first copy and EOP/empty on the last copy.
module avst_beat_repeater
  import avst_interpolator_pkg::*;
#(
  parameter int DATA_WIDTH  = 512,
  parameter int EMPTY_WIDTH = EMPTY_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [CNT_W-1:0]       factor,
  input  logic [DATA_WIDTH-1:0]  snk_data,
  input  logic                   snk_valid,
  input  logic                   snk_sop,
  input  logic                   snk_eop,
  input  logic [EMPTY_WIDTH-1:0] snk_empty,
  output logic                   snk_ready,
  output logic [DATA_WIDTH-1:0]  src_data,
  output logic                   src_valid,
  output logic                   src_sop,
  output logic                   src_eop,
  output logic [EMPTY_WIDTH-1:0] src_empty,
  input  logic                   src_ready,
  output logic                   held,
  output logic [CNT_W-1:0]       copy_count
);

  logic                  held_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  beat_meta_t            meta_reg;
  logic [CNT_W-1:0]      held_f_reg;
  logic [CNT_W-1:0]      count_reg;

  logic last_copy;
  logic capture;
  logic src_xfer;

  assign last_copy = held_reg & (count_reg == held_f_reg);
  assign snk_ready = enable & (~held_reg | (src_ready & last_copy));
  assign capture   = snk_valid & snk_ready;
  assign src_xfer  = src_valid & src_ready;

  assign src_valid  = held_reg & enable;
  assign src_data   = data_reg;
  assign src_sop    = held_reg & meta_reg.sop & (count_reg == '0);
  assign src_eop    = meta_reg.eop & last_copy;
  assign src_empty  = src_eop ? EMPTY_WIDTH'(meta_reg.empty) : '0;
  assign held       = held_reg;
  assign copy_count = count_reg;

  // A capture on the last copy replaces the beat in place, so no bubble appears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_reg   <= 1'b0;
      data_reg   <= '0;
      meta_reg   <= '0;
      held_f_reg <= '0;
      count_reg  <= '0;
    end else if (capture) begin
      held_reg       <= 1'b1;
      data_reg       <= snk_data;
      meta_reg.sop   <= snk_sop;
      meta_reg.eop   <= snk_eop;
      meta_reg.empty <= EMPTY_W'(snk_empty);
      held_f_reg     <= factor;
      count_reg      <= '0;
    end else if (src_xfer) begin
      if (last_copy) begin
        held_reg  <= 1'b0;
        count_reg <= '0;
      end else begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/avst_interpolator.sv
// Avalon-ST beat interpolator top: 64-bit control/status register plus
// the beat repeater datapath.
module avst_interpolator
  import avst_interpolator_pkg::*;
#(
  parameter int DATA_WIDTH  = 512,
  parameter int EMPTY_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   csr_write,
  input  logic [63:0]            csr_writedata,
  input  logic [7:0]             csr_byteenable,
  input  logic                   csr_read,
  output logic [63:0]            csr_readdata,
  input  logic [DATA_WIDTH-1:0]  snk_data,
  input  logic                   snk_valid,
  input  logic                   snk_sop,
  input  logic                   snk_eop,
  input  logic [EMPTY_WIDTH-1:0] snk_empty,
  output logic                   snk_ready,
  output logic [DATA_WIDTH-1:0]  src_data,
  output logic                   src_valid,
  output logic                   src_sop,
  output logic                   src_eop,
  output logic [EMPTY_WIDTH-1:0] src_empty,
  input  logic                   src_ready
);

  logic             enable_reg;
  logic [CNT_W-1:0] factor_reg;
  logic             held;
  logic [CNT_W-1:0] copy_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_reg <= 1'b0;
    end else if (csr_write && csr_byteenable[0]) begin
      enable_reg <= csr_writedata[ENABLE_BIT];
    end
  end

  // Factor bytes are individually writable through byte enables 2 and 3.
  generate
    for (genvar gi = 0; gi < CNT_W / 8; gi++) begin : g_factor_byte
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          factor_reg[gi*8 +: 8] <= 8'h00;
        end else if (csr_write && csr_byteenable[FACTOR_LSB/8 + gi]) begin
          factor_reg[gi*8 +: 8] <= csr_writedata[FACTOR_LSB + gi*8 +: 8];
        end
      end
    end
  endgenerate

  always_comb begin
    csr_readdata = '0;
    if (csr_read) begin
      csr_readdata[ENABLE_BIT]               = enable_reg;
      csr_readdata[BUSY_BIT]                 = held;
      csr_readdata[FACTOR_LSB +: CNT_W]      = factor_reg;
      csr_readdata[COUNT_LSB +: CNT_W]       = copy_count;
    end
  end

  avst_beat_repeater #(
    .DATA_WIDTH  (DATA_WIDTH),
    .EMPTY_WIDTH (EMPTY_WIDTH)
  ) u_repeater (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable_reg),
    .factor     (factor_reg),
    .snk_data   (snk_data),
    .snk_valid  (snk_valid),
    .snk_sop    (snk_sop),
    .snk_eop    (snk_eop),
    .snk_empty  (snk_empty),
    .snk_ready  (snk_ready),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_sop    (src_sop),
    .src_eop    (src_eop),
    .src_empty  (src_empty),
    .src_ready  (src_ready),
    .held       (held),
    .copy_count (copy_count)
  );

endmodule

// File: tb/tb_avst_interpolator.sv
// Scoreboard bench for avst_interpolator: stimulus pushes expected source
// beats, a negedge monitor pops and compares them.
module tb_avst_interpolator;

  localparam int DW = 512;
  localparam int EW = 6;

  logic          clk;
  logic          reset;
  logic          csr_write;
  logic [63:0]   csr_writedata;
  logic [7:0]    csr_byteenable;
  logic          csr_read;
  logic [63:0]   csr_readdata;
  logic [DW-1:0] snk_data;
  logic          snk_valid;
  logic          snk_sop;
  logic          snk_eop;
  logic [EW-1:0] snk_empty;
  logic          snk_ready;
  logic [DW-1:0] src_data;
  logic          src_valid;
  logic          src_sop;
  logic          src_eop;
  logic [EW-1:0] src_empty;
  logic          src_ready;

  avst_interpolator #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW)) dut (
    .clk            (clk),
    .reset          (reset),
    .csr_write      (csr_write),
    .csr_writedata  (csr_writedata),
    .csr_byteenable (csr_byteenable),
    .csr_read       (csr_read),
    .csr_readdata   (csr_readdata),
    .snk_data       (snk_data),
    .snk_valid      (snk_valid),
    .snk_sop        (snk_sop),
    .snk_eop        (snk_eop),
    .snk_empty      (snk_empty),
    .snk_ready      (snk_ready),
    .src_data       (src_data),
    .src_valid      (src_valid),
    .src_sop        (src_sop),
    .src_eop        (src_eop),
    .src_empty      (src_empty),
    .src_ready      (src_ready)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cur_f  = 0;
  bit   tog_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input logic [31:0] n);
    return {16{n}};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic csr_wr(input logic [63:0] d, input logic [7:0] be);
    csr_write = 1'b1;
    csr_writedata = d;
    csr_byteenable = be;
    @(posedge clk);
    #1;
    csr_write = 1'b0;
    csr_byteenable = 8'h00;
  endtask

  task automatic csr_rd(output logic [63:0] v);
    csr_read = 1'b1;
    #1;
    v = csr_readdata;
    csr_read = 1'b0;
  endtask

  // Pushes cur_f+1 expected copies, then holds the beat until accepted.
  task automatic send(input logic [DW-1:0] d, input logic s, input logic e,
                      input logic [EW-1:0] emp, output int waits);
    exp_t x;
    for (int i = 0; i <= cur_f; i++) begin
      x.data  = d;
      x.sop   = s && (i == 0);
      x.eop   = e && (i == cur_f);
      x.empty = (e && (i == cur_f)) ? emp : '0;
      exp_q.push_back(x);
    end
    snk_data = d; snk_sop = s; snk_eop = e; snk_empty = emp; snk_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!snk_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!snk_ready) begin
      errors++; checks++;
      $display("FAIL send_timeout: got snk_ready=0 after %0d cycles, required 1", waits);
    end
    @(posedge clk);
    #1;
    snk_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk({name, "_idle"}, {63'd0, src_valid}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tog_en) src_ready = ~src_ready;
    end
  end

  // Monitor: compares every presented beat against the queue head; pops on transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && src_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data=%h sop=%b eop=%b empty=%0d, required no beat",
                   src_data[31:0], src_sop, src_eop, src_empty);
        end else begin
          e = exp_q[0];
          if (src_data !== e.data || src_sop !== e.sop || src_eop !== e.eop || src_empty !== e.empty) begin
            errors++;
            $display("FAIL beat: got data=%h sop=%b eop=%b empty=%0d, required data=%h sop=%b eop=%b empty=%0d",
                     src_data[31:0], src_sop, src_eop, src_empty,
                     e.data[31:0], e.sop, e.eop, e.empty);
          end
          if (src_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [63:0] rd;
    int w;
    reset = 1'b1;
    csr_write = 1'b0; csr_writedata = '0; csr_byteenable = '0; csr_read = 1'b0;
    snk_data = '0; snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0; snk_empty = '0;
    src_ready = 1'b1;
    #2;
    chk("rst_src_valid", {63'd0, src_valid}, 64'd0);
    chk("rst_snk_ready", {63'd0, snk_ready}, 64'd0);
    csr_rd(rd);
    chk("rst_readdata", rd, 64'd0);
    #9 reset = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: F=2, three-beat packet, snk_ready every third cycle.
    csr_wr(64'h0000_0000_0002_0001, 8'h0F);
    cur_f = 2;
    send(mk(32'hD0), 1'b1, 1'b0, 6'd3, w);
    chk("t1_wait0", 64'(w), 64'd0);
    send(mk(32'hD1), 1'b0, 1'b0, 6'd0, w);
    chk("t1_wait1", 64'(w), 64'd2);
    send(mk(32'hD2), 1'b0, 1'b1, 6'd5, w);
    chk("t1_wait2", 64'(w), 64'd2);
    drain("t1");

    // Test 2: F=0 pass-through, 16 beats back to back.
    csr_wr(64'h0000_0000_0000_0001, 8'h0F);
    cur_f = 0;
    for (int i = 0; i < 16; i++) begin
      send(mk(32'h100 + 32'(i)), i == 0, i == 15, (i == 15) ? 6'd7 : 6'd0, w);
      chk("t2_no_bubble", 64'(w), 64'd0);
    end
    drain("t2");

    // Test 3: F=3 single-beat packet with src_ready toggling.
    csr_wr(64'h0000_0000_0003_0001, 8'h0F);
    cur_f = 3;
    tog_en = 1'b1;
    send(mk(32'h33), 1'b1, 1'b1, 6'd2, w);
    @(negedge clk);
    chk("t3_latency", {63'd0, src_valid}, 64'd1);
    drain("t3");
    tog_en = 1'b0;
    #2 src_ready = 1'b1;
    @(posedge clk);
    #1;

    // Test 4: F=4, disable after two copies, resume on re-enable.
    csr_wr(64'h0000_0000_0004_0001, 8'h0F);
    cur_f = 4;
    send(mk(32'h44), 1'b1, 1'b1, 6'd1, w);
    @(posedge clk);
    #1;
    csr_wr(64'h0, 8'h01);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_frozen_valid", {63'd0, src_valid}, 64'd0);
      chk("t4_frozen_ready", {63'd0, snk_ready}, 64'd0);
    end
    csr_rd(rd);
    chk("t4_readback", rd, 64'h0000_0002_0004_0002);
    @(posedge clk);
    #1;
    csr_wr(64'h1, 8'h01);
    drain("t4");

    // Test 5: factor change while holding affects only the next beat.
    csr_wr(64'h0000_0000_0001_0001, 8'h0F);
    cur_f = 1;
    send(mk(32'h55A), 1'b1, 1'b0, 6'd0, w);
    csr_wr(64'h0000_0000_0005_0000, 8'h0C);
    cur_f = 5;
    send(mk(32'h55B), 1'b0, 1'b1, 6'd4, w);
    drain("t5");

    // Test 6: asynchronous reset while holding a beat at copy_count=2.
    csr_wr(64'h0000_0000_0004_0001, 8'h0F);
    cur_f = 4;
    send(mk(32'h66), 1'b1, 1'b1, 6'd3, w);
    @(posedge clk);
    @(posedge clk);
    #1;
    csr_rd(rd);
    chk("t6_count_before", rd, 64'h0000_0002_0004_0003);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_valid", {63'd0, src_valid}, 64'd0);
    chk("t6_rst_sop_eop", {62'd0, src_sop, src_eop}, 64'd0);
    chk("t6_rst_empty", 64'(src_empty), 64'd0);
    chk("t6_rst_ready", {63'd0, snk_ready}, 64'd0);
    exp_q.delete();
    @(posedge clk);
    #2 reset = 1'b0;
    csr_rd(rd);
    chk("t6_readback", rd, 64'd0);
    @(posedge clk);
    #1;
    csr_wr(64'h1, 8'h01);
    repeat (6) @(negedge clk);
    chk("t6_no_stale", {63'd0, src_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
